// File: rtl/core_csr_pkg.sv
// Shared constants for the iwacpu machine-mode CSR unit:
// CSR addresses, op encodings, mstatus/mie/mip bit indices, interrupt causes.
package core_csr_pkg;

    // CSR addresses
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;
    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MEDELEG       = 12'h302;
    localparam logic [11:0] ADDR_MIDELEG       = 12'h303;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;

    // CSR_OP encodings
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    // mstatus bits
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;

    // mie / mip bits
    localparam int MIX_MSI = 3;
    localparam int MIX_MTI = 7;
    localparam int MIX_MEI = 11;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    // interrupt causes
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    // Counter slot -> CSR number: 0 mcycle, 1 minstret, k>=2 mhpmcounter(k+1)
    function automatic int cnt_num(input int slot);
        if (slot == 0)
            return 0;
        else if (slot == 1)
            return 2;
        else
            return slot + 1;
    endfunction

endpackage

// File: rtl/core_csr_counter.sv
// 64-bit event counter with inhibit and independent half writes.
// Ports: clk, rst, inc, inhibit, wr_lo, wr_hi, wdata[31:0], value[63:0].
module core_csr_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] cnt_q;

    // A half write suppresses the increment, so no carry leaks between halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo)
                cnt_q[31:0] <= wdata;
            if (wr_hi)
                cnt_q[63:32] <= wdata;
        end else if (inc && !inhibit) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/core_csr_unit.sv
// Machine-mode CSR unit: CSR RMW ops, trap entry/MRET, 64-bit counters, IRQs.
// Ports: CSR_* access, INSTR_RET/HPM_EVENT, TRAP_*/MRET, TRAP_VECTOR/EPC, IRQ_*.
module core_csr_unit
    import core_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_1128,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          NUM_HPM     = 4,
    localparam int         HW          = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [11:0]   CSR_ADDR,
    input  logic [1:0]    CSR_OP,
    input  logic [31:0]   CSR_WDATA,
    output logic [31:0]   CSR_RDATA,
    output logic          CSR_ILLEGAL,
    input  logic          INSTR_RET,
    input  logic [HW-1:0] HPM_EVENT,
    input  logic          TRAP_VALID,
    input  logic [31:0]   TRAP_CAUSE,
    input  logic [31:0]   TRAP_PC,
    input  logic [31:0]   TRAP_VAL,
    input  logic          MRET,
    output logic [31:0]   TRAP_VECTOR,
    output logic [31:0]   EPC,
    input  logic          IRQ_EXT,
    input  logic          IRQ_TIMER,
    input  logic          IRQ_SW,
    output logic          IRQ_PENDING,
    output logic [31:0]   IRQ_CAUSE
);

    localparam int NCNT = 2 + NUM_HPM;
    localparam logic [63:0] HPM_ONES = (64'd1 << NUM_HPM) - 64'd1;
    localparam logic [31:0] INH_MASK = 32'h5 | (HPM_ONES[31:0] << 3);

    logic        st_mie;
    logic        st_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] medeleg_q;
    logic [31:0] mideleg_q;
    logic [31:0] minh_q;

    logic [NCNT-1:0][63:0] cnt_val;

    logic [31:0] mip_v;
    logic [31:0] rval;
    logic        impl;
    logic [31:0] wval;
    logic        wr_try;
    logic        ro_addr;
    logic        ill;
    logic        do_wr;

    always_comb begin
        mip_v = '0;
        mip_v[MIX_MEI] = IRQ_EXT;
        mip_v[MIX_MTI] = IRQ_TIMER;
        mip_v[MIX_MSI] = IRQ_SW;
    end

    // Read decode: raw value of the addressed CSR and whether it exists.
    always_comb begin
        impl = 1'b0;
        rval = '0;
        case (CSR_ADDR)
            ADDR_MVENDORID,
            ADDR_MARCHID,
            ADDR_MIMPID: impl = 1'b1;
            ADDR_MHARTID: begin
                impl = 1'b1;
                rval = HART_ID;
            end
            ADDR_MSTATUS: begin
                impl = 1'b1;
                rval = MSTATUS_MPP_RO;
                rval[MSTATUS_MIE] = st_mie;
                rval[MSTATUS_MPIE] = st_mpie;
            end
            ADDR_MISA: begin
                impl = 1'b1;
                rval = MISA_VAL;
            end
            ADDR_MEDELEG: begin
                impl = 1'b1;
                rval = medeleg_q;
            end
            ADDR_MIDELEG: begin
                impl = 1'b1;
                rval = mideleg_q;
            end
            ADDR_MIE: begin
                impl = 1'b1;
                rval = mie_q;
            end
            ADDR_MTVEC: begin
                impl = 1'b1;
                rval = mtvec_q;
            end
            ADDR_MCOUNTINHIBIT: begin
                impl = 1'b1;
                rval = minh_q;
            end
            ADDR_MSCRATCH: begin
                impl = 1'b1;
                rval = mscratch_q;
            end
            ADDR_MEPC: begin
                impl = 1'b1;
                rval = mepc_q;
            end
            ADDR_MCAUSE: begin
                impl = 1'b1;
                rval = mcause_q;
            end
            ADDR_MTVAL: begin
                impl = 1'b1;
                rval = mtval_q;
            end
            ADDR_MIP: begin
                impl = 1'b1;
                rval = mip_v;
            end
            default: ;
        endcase
        for (int i = 0; i < NCNT; i++) begin
            if (CSR_ADDR == ADDR_MCYCLE + 12'(cnt_num(i))) begin
                impl = 1'b1;
                rval = cnt_val[i][31:0];
            end
            if (CSR_ADDR == ADDR_MCYCLEH + 12'(cnt_num(i))) begin
                impl = 1'b1;
                rval = cnt_val[i][63:32];
            end
        end
        for (int k = 0; k < NUM_HPM; k++) begin
            if (CSR_ADDR == ADDR_MHPMEVENT3 + 12'(k))
                impl = 1'b1;
        end
    end

    always_comb begin
        case (CSR_OP)
            OP_RS:   wval = rval | CSR_WDATA;
            OP_RC:   wval = rval & ~CSR_WDATA;
            default: wval = CSR_WDATA;
        endcase
    end

    // RS/RC with a zero operand is a pure read, even on read-only CSRs.
    assign wr_try  = (CSR_OP == OP_RW)
                   || ((CSR_OP != OP_NONE) && (CSR_WDATA != 32'd0));
    assign ro_addr = (CSR_ADDR[11:10] == 2'b11) || (CSR_ADDR == ADDR_MISA);
    assign ill     = ((CSR_OP != OP_NONE) && !impl) || (wr_try && ro_addr);
    assign do_wr   = wr_try && !ill && !TRAP_VALID;

    assign CSR_ILLEGAL = ill;
    assign CSR_RDATA   = ill ? 32'd0 : rval;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            medeleg_q  <= '0;
            mideleg_q  <= '0;
            minh_q     <= '0;
        end else if (TRAP_VALID) begin
            mepc_q   <= TRAP_PC & ~32'd3;
            mcause_q <= TRAP_CAUSE;
            mtval_q  <= TRAP_VAL;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else begin
            if (MRET) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (do_wr && CSR_ADDR == ADDR_MSTATUS) begin
                st_mie  <= wval[MSTATUS_MIE];
                st_mpie <= wval[MSTATUS_MPIE];
            end
            if (do_wr) begin
                case (CSR_ADDR)
                    ADDR_MEDELEG:       medeleg_q  <= wval;
                    ADDR_MIDELEG:       mideleg_q  <= wval;
                    ADDR_MIE:           mie_q      <= wval & MIE_MASK;
                    ADDR_MTVEC:         mtvec_q    <= wval & ~32'd2;
                    ADDR_MCOUNTINHIBIT: minh_q     <= wval & INH_MASK;
                    ADDR_MSCRATCH:      mscratch_q <= wval;
                    ADDR_MEPC:          mepc_q     <= wval & ~32'd3;
                    ADDR_MCAUSE:        mcause_q   <= wval;
                    ADDR_MTVAL:         mtval_q    <= wval;
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        localparam int N = cnt_num(g);
        logic inc;
        if (g == 0) begin : g_cy
            assign inc = 1'b1;
        end else if (g == 1) begin : g_ir
            assign inc = INSTR_RET;
        end else begin : g_hpm
            assign inc = HPM_EVENT[g-2];
        end
        core_csr_counter u_cnt (
            .clk     (CLK),
            .rst     (RST),
            .inc     (inc),
            .inhibit (minh_q[N]),
            .wr_lo   (do_wr && CSR_ADDR == ADDR_MCYCLE + 12'(N)),
            .wr_hi   (do_wr && CSR_ADDR == ADDR_MCYCLEH + 12'(N)),
            .wdata   (wval),
            .value   (cnt_val[g])
        );
    end

    // Vectored mode only applies to interrupts.
    always_comb begin
        TRAP_VECTOR = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && TRAP_CAUSE[31])
            TRAP_VECTOR = TRAP_VECTOR + {25'd0, TRAP_CAUSE[4:0], 2'b00};
    end

    assign EPC = mepc_q;

    logic [31:0] irq_act;
    assign irq_act     = mie_q & mip_v;
    assign IRQ_PENDING = st_mie && (irq_act != 32'd0);

    always_comb begin
        IRQ_CAUSE = '0;
        if (IRQ_PENDING) begin
            if (irq_act[MIX_MEI])
                IRQ_CAUSE = CAUSE_MEI;
            else if (irq_act[MIX_MSI])
                IRQ_CAUSE = CAUSE_MSI;
            else
                IRQ_CAUSE = CAUSE_MTI;
        end
    end

endmodule

// File: doc/core_csr_unit.md
# core_csr_unit

Parametrised machine-mode CSR unit for the iwacpu core. It performs the CSR read-modify-write instructions internally (RW/RS/RC), sequences trap entry and MRET, and runs 64-bit cycle/instret/HPM counters with inhibit. It also tracks interrupt pending/enable state and raises an interrupt request to the core. It sits beside the execute stage, which supplies decoded CSR ops, retire pulses and trap requests.

## Interface
- HART_ID, 0: value read from mhartid (F14h).
- MISA_VAL, 32'h4000_1128: value read from misa (301h), which is read-only.
- RESET_MTVEC, 32'h0000_0000: reset value of mtvec.
- NUM_HPM, 4: number of implemented mhpmcounter3.. counters, legal range 0..29.
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CSR_ADDR  in  12  CSR address.
- CSR_OP  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- CSR_WDATA  in  32  operand (rs1 or zimm).
- CSR_RDATA  out  32  old value of the addressed CSR.
- CSR_ILLEGAL  out  1  access is illegal.
- INSTR_RET  in  1  one instruction retired this cycle.
- HPM_EVENT  in  NUM_HPM  per-counter event increment strobes.
- TRAP_VALID  in  1  take a trap this cycle.
- TRAP_CAUSE  in  32  mcause value; bit 31 marks an interrupt.
- TRAP_PC  in  32  PC to save in mepc.
- TRAP_VAL  in  32  value to save in mtval.
- MRET  in  1  execute MRET this cycle.
- TRAP_VECTOR  out  32  trap target PC.
- EPC  out  32  current mepc.
- IRQ_EXT, IRQ_TIMER, IRQ_SW  in  1 each  level interrupt lines.
- IRQ_PENDING  out  1  an enabled interrupt is pending.
- IRQ_CAUSE  out  32  cause code for IRQ_PENDING.

## Operation
- **Write value:** RW gives new = WDATA. RS gives old | WDATA. RC gives old & ~WDATA.
- **No-write case:** RS or RC with WDATA == 0 performs no write and is never illegal.
- **Illegal access:** CSR_ILLEGAL is set when either condition holds:
  - CSR_OP != 00 and the address is unimplemented;
  - a write is attempted to a read-only address (ADDR[11:10] == 11, or misa).
- **Effect of an illegal access:** the state is unchanged and CSR_RDATA is 0.
- **Implemented CSRs:**
  - mvendorid, marchid, mimpid read 0.
  - mhartid reads HART_ID.
  - mstatus (300h): MIE bit 3, MPIE bit 7, MPP bits 12:11. MPP is read-only 11; all other bits read 0.
  - misa, medeleg (302h), mideleg (303h): medeleg and mideleg are full 32-bit.
  - mie (304h): only MEIE 11, MTIE 7, MSIE 3 are writable.
  - mtvec (305h): bit 1 is forced to 0 (WARL), so MODE is 0 or 1.
  - mscratch (340h).
  - mepc (341h): bits 1:0 are forced to 0.
  - mcause (342h) and mtval (343h).
  - mip (344h): read-only. MEIP = IRQ_EXT, MTIP = IRQ_TIMER, MSIP = IRQ_SW.
  - mcountinhibit (320h): CY bit 0, IR bit 2, HPMn bit n for 3 ≤ n < 3+NUM_HPM. All other bits read 0.
  - mcycle B00/B80, minstret B02/B82, mhpmcounterN B0N/B8N for N < 3+NUM_HPM.
  - mhpmeventN (323h..) are implemented as read-0 and write-ignored.
- **Counters:**
  - mcycle increments every cycle.
  - minstret increments on INSTR_RET.
  - mhpmcounterN increments on HPM_EVENT[N-3].
  - Each counter holds while its inhibit bit is set.
  - A write to a half replaces that half only. In a write cycle the counter does not increment, and no carry crosses into the other half.
  - Counters wrap at 2^64 to 0.
- **Trap entry (TRAP_VALID):** the following take effect at the next edge.
  - mepc ← TRAP_PC & ~3; mcause ← TRAP_CAUSE; mtval ← TRAP_VAL.
  - MPIE ← MIE; MIE ← 0.
- **MRET:** MIE ← MPIE; MPIE ← 1.
- **Priority when events coincide:**
  - TRAP_VALID beats MRET; the MRET is ignored.
  - TRAP_VALID beats a CSR write; the write is discarded, CSR_ILLEGAL is still reported, and counters still increment.
  - MRET together with a CSR write to mstatus: MRET wins.
- **TRAP_VECTOR:** base = {mtvec[31:2], 2'b00}.
  - If MODE == 1 and TRAP_CAUSE[31] is set: base + 4·TRAP_CAUSE[4:0].
  - Otherwise: base.
- **Interrupts:**
  - IRQ_PENDING = MIE & |(mie & mip).
  - IRQ_CAUSE priority is MEI (32'h8000_000B), then MSI (…03), then MTI (…07). IRQ_CAUSE is 0 when nothing is pending.

## Timing
- CSR_RDATA, CSR_ILLEGAL, TRAP_VECTOR, EPC, IRQ_PENDING and IRQ_CAUSE are combinational from current state and inputs, with zero latency.
- All state updates take effect at the next CLK edge, so a read in the same cycle as a write returns the old value.
- Reset state (RST high at an edge):
  - all writable CSRs are 0, except mtvec = RESET_MTVEC;
  - counters are 0 and mcountinhibit is 0.
- Outputs after reset:
  - CSR_RDATA = 0 for CSR_OP = 00 at address 000h.
  - EPC = 0, IRQ_PENDING = 0, IRQ_CAUSE = 0.
- RST overrides every other input in that cycle. There is no multi-cycle state, so reset mid-operation leaves no residue.

## Structure
- Package core_csr_pkg holds:
  - CSR address localparams;
  - CSR_OP encodings;
  - mstatus, mie and mip bit indices;
  - interrupt cause constants.
- Sub-module core_csr_counter: a 64-bit counter with inputs inc, inhibit, wr_lo, wr_hi and wdata. It is instantiated 2+NUM_HPM times through a generate loop.

## Test plan
- **Reset and RW:** after reset, RW 305h with 32'h8000_0103 → next-cycle read of 305h gives 32'h8000_0101.
- **Trap entry:**
  - Setup: mstatus.MIE = 1, MODE = 1.
  - Stimulus: TRAP_VALID with cause 32'h8000_0007 and PC 32'h0000_1236.
  - Required: same cycle, TRAP_VECTOR = 32'h8000_011C. Next cycle: mepc 32'h1234, MIE 0, MPIE 1.
  - Then MRET → MIE 1.
- **Counter wrap:**
  - Setup: write B80 = FFFF_FFFF, then B00 = FFFF_FFFE; mcycle holds during each write cycle.
  - Required: the cycle after the B00 write, mcycle reads FFFF_FFFF_FFFF_FFFE; two cycles later it is 0.
  - Inhibit: setting mcountinhibit bit 0 freezes mcycle.
- **Illegal accesses:**
  - RW F14h gives CSR_ILLEGAL = 1 and mhartid is unchanged.
  - RS F14h with WDATA 0 gives CSR_ILLEGAL = 0 and CSR_RDATA = HART_ID.
  - RW 7C0h (unimplemented) gives CSR_ILLEGAL = 1.
- **Interrupt priority:** with MIE = 1, mie = 32'h888 and IRQ_TIMER = IRQ_EXT = 1 → IRQ_CAUSE = 32'h8000_000B. Dropping IRQ_EXT → 32'h8000_0007.
- **Simultaneous events:** TRAP_VALID together with MRET and an RW of 340h → trap state updates, mscratch is unchanged, and MIE = 0.
